// File: rtl/slt_serial_32.sv
// Nibble-serial 32-bit set-less-than unit (slt/sltu) with start/done handshake.
// Scans captured operands from nibble 7 down to nibble 0 and stops at the first difference.
module slt_serial_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        eq
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [31:0] a_cap;
  logic [31:0] b_cap;
  logic        signed_cap;

  logic [3:0]  a_nib [8];
  logic [3:0]  b_nib [8];
  logic [3:0]  a_cur;
  logic [3:0]  b_cur;
  logic        sign_diff;

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_nib
      assign a_nib[gi] = a_cap[4*gi+3:4*gi];
      assign b_nib[gi] = b_cap[4*gi+3:4*gi];
    end
  endgenerate

  assign a_cur = a_nib[idx];
  assign b_cur = b_nib[idx];

  // Differing sign bits decide a signed compare outright: the negative operand is smaller.
  assign sign_diff = signed_cap && (idx == 3'd7) && (a_cap[31] != b_cap[31]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      result     <= 32'h0;
      eq         <= 1'b0;
      idx        <= 3'd7;
      a_cap      <= 32'h0;
      b_cap      <= 32'h0;
      signed_cap <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_cap      <= a;
            b_cap      <= b;
            signed_cap <= is_signed;
            idx        <= 3'd7;
            state      <= SCAN;
            busy       <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SCAN: begin
          if (sign_diff) begin
            result <= {31'h0, a_cap[31]};
            eq     <= 1'b0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (a_cur != b_cur) begin
            result <= {31'h0, (a_cur < b_cur)};
            eq     <= 1'b0;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else if (idx == 3'd0) begin
            result <= 32'h0;
            eq     <= 1'b1;
            state  <= DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            idx <= idx - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/slt_serial_32.md
# slt_serial_32

Multi-cycle 32-bit set-less-than unit for the ALU's low-area datapath. It replaces the full 32-bit subtractor compare with a nibble-serial magnitude scan from MSB to LSB that stops at the first differing nibble. The result is the same 32-bit 0/1 word the single-cycle compare produces. It sits beside the ALU and is driven by the control unit through a start/done handshake, with selectable signed (slt) or unsigned (sltu) compare.

## Interface
- No parameters; width fixed at 32 bits, scan step fixed at 4 bits (8 nibbles).
- clk  input  1  rising-edge clock; the only clock.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled only when busy=0.
- is_signed  input  1  1 = signed (slt), 0 = unsigned (sltu); captured with start.
- a  input  32  operand A; captured with start.
- b  input  32  operand B; captured with start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse when result/eq are updated.
- result  output  32  32'h00000001 if A < B, else 32'h00000000.
- eq  output  1  1 if A == B.

## Operation
- States:
  - IDLE: busy=0, done=0.
  - SCAN: busy=1, done=0.
  - DONE: busy=0, done=1.
- IDLE/DONE + start=1:
  - Capture a, b and is_signed into internal registers.
  - Set nibble index idx=7.
  - Go to SCAN.
- IDLE/DONE + start=0:
  - Go to IDLE from either state.
  - result and eq hold their values.
- SCAN, each cycle, with the captured operands as A and B; the first matching rule below applies:
  - Signed and idx=7 and A[31]≠B[31]: result=A[31], eq=0, go to DONE.
  - A[4*idx+3:4*idx] ≠ B[4*idx+3:4*idx]: result=(A nibble < B nibble, unsigned 4-bit compare), eq=0, go to DONE.
  - idx=0 and nibbles equal: result=0, eq=1, go to DONE.
  - Otherwise: idx=idx-1, stay in SCAN.
- Signed compare with equal sign bits reduces to unsigned magnitude compare of the two's-complement words. No subtraction is performed.
- start while busy=1 is ignored. The captured operands are not disturbed, and input changes during SCAN have no effect.
- result and eq change only on the edge that enters DONE. They hold until the next completion.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, busy=0, done=0, result=32'h0, eq=0, idx=7, captured operands cleared. Takes effect immediately, with no clock edge needed.
- Reset mid-SCAN aborts the compare. result/eq return to 0 and no done pulse is issued. After rst_n deasserts, the first start is accepted normally.
- Edge numbering: start is sampled at edge 0. Let k be the number of nibbles examined (1..8).
  - k=1 when the sign bits differ (signed) or nibble 7 differs.
  - k=8 when the operands are equal or only nibble 0 differs.
- busy is high from after edge 0 until edge k.
- result, eq and done are registered at edge k. done is high for exactly the cycle between edges k and k+1.
- Throughput: start may be asserted in the DONE cycle. It is accepted at edge k+1, giving back-to-back operation with no idle gap.
- Latency bounds: minimum 1 cycle (start edge to done), maximum 8 cycles.

## Test plan
- Unsigned, a=32'h00000005, b=32'h00000007, start at edge 0 -> done during cycle after edge 8, result=32'h00000001, eq=0; busy high for 8 cycles.
- Signed, a=32'h80000000, b=32'h00000001 -> done after edge 1, result=1. Repeat unsigned -> done after edge 1, result=0.
- a=b=32'hDEADBEEF (both modes) -> done after edge 8, result=0, eq=1.
- Signed, a=32'hFFFFFFF0 (-16), b=32'hFFFFFFFF (-1) -> done after edge 8, result=1. Swapped operands -> result=0.
- Start asserted with new operands on every cycle during SCAN -> ignored, and the first compare's result is unchanged. Start in the DONE cycle -> accepted; the second done follows with no idle cycle.
- rst_n pulsed low mid-SCAN (after edge 3 of an 8-nibble compare) -> busy, done, result and eq immediately 0, with no done pulse. A fresh compare afterwards completes correctly.
